// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared widths, frame constants and loader states
package prog_loader_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int MAXLEN = 2 ** ADDR_W;
    // Index/count must hold MAXLEN itself, so one bit wider than the address.
    localparam int IDX_W  = ADDR_W + 1;
    localparam logic [DATA_W-1:0] HEADER = 8'hA5;

    typedef enum logic [2:0] {
        HDR,
        CNT,
        DATA,
        WR,
        SUM,
        RUN,
        ERR
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the CPU instruction memory
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iValid,
    input  logic [DATA_W-1:0] iData,
    output logic              oReady,
    output logic              oWE,
    output logic [ADDR_W-1:0] oWAddr,
    output logic [DATA_W-1:0] oWData,
    output logic              oCpuRst,
    output logic              oDone,
    output logic              oError
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                xfer;

    assign xfer = iValid && ready_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            HDR: begin
                if (xfer && iData == HEADER) state_d = CNT;
            end
            CNT: begin
                if (xfer) begin
                    if (iData == '0 || iData > DATA_W'(MAXLEN)) begin
                        state_d = ERR;
                    end else begin
                        cnt_d   = iData[IDX_W-1:0];
                        idx_d   = '0;
                        acc_d   = iData;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    acc_d   = acc_q + iData;
                    we_d    = 1'b1;
                    waddr_d = idx_q[ADDR_W-1:0];
                    wdata_d = iData;
                    state_d = WR;
                end
            end
            WR: begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_d == cnt_q) ? SUM : DATA;
            end
            SUM: begin
                if (xfer) state_d = (iData == acc_q) ? RUN : ERR;
            end
            RUN, ERR: begin
                if (xfer && iData == HEADER) state_d = CNT;
            end
            default: state_d = HDR;
        endcase
        // Status outputs are decoded from the next state so they register in step with it.
        ready_d   = (state_d != WR);
        cpu_rst_d = (state_d != RUN);
        done_d    = (state_d == RUN);
        error_d   = (state_d == ERR);
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q   <= HDR;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign oReady  = ready_q;
    assign oWE     = we_q;
    assign oWAddr  = waddr_q;
    assign oWData  = wdata_q;
    assign oCpuRst = cpu_rst_q;
    assign oDone   = done_q;
    assign oError  = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              rdy, we, cpu_rst, done, err;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    int errors = 0;
    int checks = 0;
    bit chk_rdy = 1'b0;

    logic [11:0] obs_q[$];
    logic [11:0] exp_q[$];
    logic [7:0]  pl_q[$];

    prog_loader dut (
        .iClk(clk), .iReset(rst), .iValid(valid), .iData(data),
        .oReady(rdy), .oWE(we), .oWAddr(waddr), .oWData(wdata),
        .oCpuRst(cpu_rst), .oDone(done), .oError(err)
    );

    always #5 clk = ~clk;

    // Memory side: every write the instruction memory would sample.
    always @(posedge clk) if (we === 1'b1) obs_q.push_back({waddr, wdata});

    always @(negedge clk) begin
        if (chk_rdy) begin
            checks++;
            if (rdy !== ~we) begin
                errors++;
                $display("FAIL ready_vs_we: oReady=%b oWE=%b required oReady=~oWE", rdy, we);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: a frame with legal count writes every payload byte in order and is
    // accepted only when the trailing byte equals (count + sum of payload) mod 256.
    function automatic bit model_frame(input logic [7:0] cnt, input logic [7:0] sum);
        logic [7:0] acc;
        if (cnt == 0 || cnt > 16) return 1'b0;
        acc = cnt;
        for (int i = 0; i < int'(cnt); i++) begin
            exp_q.push_back({4'(i), pl_q[i]});
            acc = acc + pl_q[i];
        end
        return acc == sum;
    endfunction

    function automatic int write_diffs();
        int n;
        n = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            valid = 1'b0;
            data  = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        valid = 1'b1;
        data  = b;
        while (rdy !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k == 64) begin
            errors++;
            $display("FAIL send_timeout: oReady=%b required 1 within 64 cycles", rdy);
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    function automatic int gap(input int maxgap);
        return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
    endfunction

    task automatic send_frame(input logic [7:0] cnt, input logic [7:0] sum, input int maxgap);
        send_byte(HEADER);
        idle(gap(maxgap));
        send_byte(cnt);
        if (cnt >= 1 && cnt <= 16) begin
            for (int i = 0; i < int'(cnt); i++) begin
                idle(gap(maxgap));
                send_byte(pl_q[i]);
            end
            idle(gap(maxgap));
            send_byte(sum);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rdy, we, waddr, wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h required all 0", rdy, we, waddr, wdata);
        end
        checks++;
        if ({cpu_rst, done, err} !== 3'b100) begin
            errors++;
            $display("FAIL reset_status: got %b required 100", {cpu_rst, done, err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b required 1", rdy);
        end
    endtask

    task automatic test_basic_load();
        bit ok;
        pl_q = {};
        pl_q.push_back(8'h11); pl_q.push_back(8'h22); pl_q.push_back(8'h33);
        ok = model_frame(8'h03, 8'h69);
        send_byte(HEADER);
        send_byte(8'h03);
        send_byte(8'h11);
        checks++;
        if ({we, waddr, wdata, rdy} !== {1'b1, 4'h0, 8'h11, 1'b0}) begin
            errors++;
            $display("FAIL first_write_timing: we=%b addr=%h data=%h rdy=%b required 1 0 11 0", we, waddr, wdata, rdy);
        end
        send_byte(8'h22);
        send_byte(8'h33);
        checks++;
        if (cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL hold_before_sum: oCpuRst=%b required 1", cpu_rst);
        end
        send_byte(8'h69);
        checks++;
        if ({cpu_rst, done, err} !== {~ok, ok, ~ok}) begin
            errors++;
            $display("FAIL basic_status: got %b required %b", {cpu_rst, done, err}, {~ok, ok, ~ok});
        end
        checks++;
        if (write_diffs() != 0) begin
            errors++;
            $display("FAIL basic_writes: got %p required %p", obs_q, exp_q);
        end
        obs_q = {}; exp_q = {};
    endtask

    task automatic test_bad_checksum();
        bit ok;
        pl_q = {};
        pl_q.push_back(8'h10); pl_q.push_back(8'h20);
        ok = model_frame(8'h02, 8'h00);
        send_frame(8'h02, 8'h00, 0);
        checks++;
        if ({cpu_rst, done, err} !== {~ok, ok, ~ok}) begin
            errors++;
            $display("FAIL badsum_status: got %b required %b", {cpu_rst, done, err}, {~ok, ok, ~ok});
        end
        checks++;
        if (write_diffs() != 0) begin
            errors++;
            $display("FAIL badsum_writes: got %p required %p", obs_q, exp_q);
        end
        obs_q = {}; exp_q = {};
    endtask

    task automatic test_bad_count();
        logic [7:0] cnts[2];
        bit ok;
        cnts[0] = 8'd0;
        cnts[1] = 8'd17;
        foreach (cnts[j]) begin
            pl_q = {};
            ok = model_frame(cnts[j], 8'h00);
            send_frame(cnts[j], 8'h00, 1);
            idle(2);
            checks++;
            if ({cpu_rst, done, err} !== {~ok, ok, ~ok} || obs_q.size() != 0) begin
                errors++;
                $display("FAIL badcount_%0d: status=%b writes=%0d required %b and 0 writes",
                         cnts[j], {cpu_rst, done, err}, obs_q.size(), {~ok, ok, ~ok});
            end
        end
        pl_q = {};
        pl_q.push_back(8'hFF);
        ok = model_frame(8'h01, 8'h00);
        send_frame(8'h01, 8'h00, 0);
        checks++;
        if ({cpu_rst, done, err} !== {~ok, ok, ~ok}) begin
            errors++;
            $display("FAIL recover_status: got %b required %b", {cpu_rst, done, err}, {~ok, ok, ~ok});
        end
        checks++;
        if (write_diffs() != 0) begin
            errors++;
            $display("FAIL recover_writes: got %p required %p", obs_q, exp_q);
        end
        obs_q = {}; exp_q = {};
    endtask

    task automatic test_full_random_gaps();
        logic [7:0] s;
        bit ok;
        pl_q = {};
        s = 8'd16;
        for (int i = 0; i < 16; i++) begin
            pl_q.push_back(8'($urandom));
            s = s + pl_q[i];
        end
        ok = model_frame(8'd16, s);
        chk_rdy = 1'b1;
        send_frame(8'd16, s, 3);
        chk_rdy = 1'b0;
        checks++;
        if ({cpu_rst, done, err} !== {~ok, ok, ~ok}) begin
            errors++;
            $display("FAIL full_status: got %b required %b", {cpu_rst, done, err}, {~ok, ok, ~ok});
        end
        checks++;
        if (write_diffs() != 0) begin
            errors++;
            $display("FAIL full_writes: got %p required %p", obs_q, exp_q);
        end
        obs_q = {}; exp_q = {};
    endtask

    task automatic test_random_frames();
        logic [7:0] cnt, s;
        bit ok;
        for (int f = 0; f < 8; f++) begin
            cnt  = 8'($urandom_range(18, 0));
            pl_q = {};
            s    = cnt;
            if (cnt <= 16) begin
                for (int i = 0; i < int'(cnt); i++) begin
                    pl_q.push_back(8'($urandom));
                    s = s + pl_q[i];
                end
            end
            if ($urandom_range(1, 0) == 0) s = s + 8'($urandom_range(255, 1));
            ok = model_frame(cnt, s);
            send_frame(cnt, s, 2);
            idle(1);
            checks++;
            if ({cpu_rst, done, err} !== {~ok, ok, ~ok}) begin
                errors++;
                $display("FAIL rand_status_%0d: cnt=%0d got %b required %b", f, cnt, {cpu_rst, done, err}, {~ok, ok, ~ok});
            end
            checks++;
            if (write_diffs() != 0) begin
                errors++;
                $display("FAIL rand_writes_%0d: got %p required %p", f, obs_q, exp_q);
            end
            obs_q = {}; exp_q = {};
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b0, b1;
        bit ok;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        exp_q.push_back({4'h0, b0});
        exp_q.push_back({4'h1, b1});
        send_byte(HEADER);
        send_byte(8'h04);
        send_byte(b0);
        send_byte(b1);
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 8'h5A;
        @(negedge clk);
        checks++;
        if ({we, cpu_rst, done, err} !== 4'b0100) begin
            errors++;
            $display("FAIL midreset_state: we/cpu/done/err=%b required 0100", {we, cpu_rst, done, err});
        end
        rst = 1'b0;
        valid = 1'b0;
        idle(2);
        send_byte(8'h11);
        send_byte(8'h04);
        send_byte(8'h22);
        send_byte(8'h33);
        idle(2);
        checks++;
        if ({cpu_rst, done, err} !== 3'b100) begin
            errors++;
            $display("FAIL junk_status: got %b required 100", {cpu_rst, done, err});
        end
        checks++;
        if (write_diffs() != 0) begin
            errors++;
            $display("FAIL midreset_writes: got %p required %p", obs_q, exp_q);
        end
        obs_q = {}; exp_q = {};
        pl_q = {};
        pl_q.push_back(8'h3C); pl_q.push_back(8'hC4);
        ok = model_frame(8'h02, 8'h02);
        send_frame(8'h02, 8'h02, 1);
        checks++;
        if ({cpu_rst, done, err} !== {~ok, ok, ~ok} || write_diffs() != 0) begin
            errors++;
            $display("FAIL after_reset_load: status=%b writes=%p required %b %p", {cpu_rst, done, err}, obs_q, {~ok, ok, ~ok}, exp_q);
        end
        obs_q = {}; exp_q = {};
    endtask

    task automatic test_reload_run();
        bit ok;
        checks++;
        if ({cpu_rst, done, err} !== 3'b010) begin
            errors++;
            $display("FAIL reload_precond: got %b required 010", {cpu_rst, done, err});
        end
        pl_q = {};
        pl_q.push_back(8'h0F);
        ok = model_frame(8'h01, 8'h10);
        send_byte(HEADER);
        checks++;
        if ({cpu_rst, done} !== 2'b10) begin
            errors++;
            $display("FAIL reload_hold: cpu/done=%b required 10", {cpu_rst, done});
        end
        send_byte(8'h01);
        send_byte(8'h0F);
        send_byte(8'h10);
        checks++;
        if ({cpu_rst, done, err} !== {~ok, ok, ~ok}) begin
            errors++;
            $display("FAIL reload_status: got %b required %b", {cpu_rst, done, err}, {~ok, ok, ~ok});
        end
        checks++;
        if (write_diffs() != 0) begin
            errors++;
            $display("FAIL reload_writes: got %p required %p", obs_q, exp_q);
        end
        obs_q = {}; exp_q = {};
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_bad_checksum();
        test_bad_count();
        test_full_random_gaps();
        test_random_frames();
        test_reset_midframe();
        test_reload_run();
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
